// File: rtl/pipeline_hazard_ctl_pkg.sv
// Shared constants for the pipeline hazard controller and the ID-stage decoder.
// Holds the FSM state encoding, the shadow-register layout and the RAW match helper.
package pipeline_hazard_ctl_pkg;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  localparam logic [4:0] REG_X0 = 5'd0;

  localparam logic [6:0] R_FORMAT = 7'b0110011;
  localparam logic [6:0] I_FORMAT = 7'b0010011;
  localparam logic [6:0] LOAD     = 7'b0000011;
  localparam logic [6:0] STORE    = 7'b0100011;
  localparam logic [6:0] BEQ      = 7'b1100011;

  typedef struct packed {
    logic [4:0] rd;
    logic       wr;
    logic       ld;
  } ex_shadow_t;

  // A writer to x0 never creates a dependency.
  function automatic logic reg_hit(input logic [4:0] rs, input logic use_rs,
                                   input logic [4:0] rd);
    return (rd != REG_X0) && use_rs && (rs == rd);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctl_if.sv
// ID-stage request / hazard-control response bundle between the pipeline and the controller.
interface pipeline_hazard_ctl_if;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic [4:0] id_rd;
  logic       id_reg_write;
  logic       id_mem_read;
  logic       id_halt;
  logic       ex_branch_taken;
  logic       hazard_detected;
  logic       pc_write;
  logic       ifid_write;
  logic       ifid_flush;
  logic       idex_flush;
  logic       halt_done;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_reg_write,
           id_mem_read, id_halt, ex_branch_taken,
    input  hazard_detected, pc_write, ifid_write, ifid_flush, idex_flush, halt_done
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_reg_write,
           id_mem_read, id_halt, ex_branch_taken,
    output hazard_detected, pc_write, ifid_write, ifid_flush, idex_flush, halt_done
  );
endinterface

// File: rtl/pipeline_hazard_ctl_hazard_cmp.sv
// Combinational source/destination match and stall equation.
// With forwarding only a load in EX can stall; without it any EX or MEM writer can.
module hazard_cmp
  import pipeline_hazard_ctl_pkg::*;
#(
  parameter int FORWARDING = 1
) (
  input  logic [4:0]  i_id_rs1,
  input  logic [4:0]  i_id_rs2,
  input  logic        i_use_rs1,
  input  logic        i_use_rs2,
  input  ex_shadow_t  i_ex,
  input  logic [4:0]  i_mem_rd,
  input  logic        i_mem_wr,
  output logic        o_stall
);

  logic w_ex_hit;
  logic w_mem_hit;

  assign w_ex_hit  = reg_hit(i_id_rs1, i_use_rs1, i_ex.rd) |
                     reg_hit(i_id_rs2, i_use_rs2, i_ex.rd);
  assign w_mem_hit = reg_hit(i_id_rs1, i_use_rs1, i_mem_rd) |
                     reg_hit(i_id_rs2, i_use_rs2, i_mem_rd);

  assign o_stall = (FORWARDING != 0) ? (i_ex.ld & i_ex.wr & w_ex_hit)
                                     : ((i_ex.wr & w_ex_hit) | (i_mem_wr & w_mem_hit));

endmodule

// File: rtl/pipeline_hazard_ctl.sv
// Hazard and sequencing controller for the 5-stage pipeline: load-use/RAW stalls,
// wrong-path flush on taken branch, and HALT drain sequencing with a sticky done flag.
//
// state  | meaning
// RUN    | normal issue; branch flush > stall > halt entry > advance
// DRAIN  | HALT left ID; older instructions retire while counter runs down
// HALTED | pipeline empty; halt_done held until reset
module pipeline_hazard_ctl
  import pipeline_hazard_ctl_pkg::*;
#(
  parameter int FORWARDING   = 1,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipeline_hazard_ctl_if.slave  bus
);

  localparam logic [3:0] LP_DRAIN = 4'(DRAIN_CYCLES);

  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  ex_shadow_t  r_ex;
  logic [4:0]  r_mem_rd;
  logic        r_mem_wr;

  logic [1:0]  w_state_nxt;
  logic [3:0]  w_cnt_nxt;
  ex_shadow_t  w_ex_nxt;
  logic        w_stall;
  logic        w_hz;
  logic        w_pc_wr;
  logic        w_ifid_wr;
  logic        w_ifid_fl;
  logic        w_idex_fl;
  logic        w_done;

  hazard_cmp #(.FORWARDING(FORWARDING)) u_cmp (
    .i_id_rs1  (bus.id_rs1),
    .i_id_rs2  (bus.id_rs2),
    .i_use_rs1 (bus.id_use_rs1),
    .i_use_rs2 (bus.id_use_rs2),
    .i_ex      (r_ex),
    .i_mem_rd  (r_mem_rd),
    .i_mem_wr  (r_mem_wr),
    .o_stall   (w_stall)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ex_nxt    = '0;
    w_hz        = 1'b0;
    w_pc_wr     = 1'b0;
    w_ifid_wr   = 1'b0;
    w_ifid_fl   = 1'b0;
    w_idex_fl   = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (bus.ex_branch_taken) begin
          w_ifid_fl = 1'b1;
          w_idex_fl = 1'b1;
          w_hz      = 1'b1;
          w_pc_wr   = 1'b1;
          w_ifid_wr = 1'b1;
        end else if (w_stall) begin
          w_hz = 1'b1;
        end else if (bus.id_halt) begin
          w_hz        = 1'b1;
          w_state_nxt = ST_DRAIN;
          w_cnt_nxt   = LP_DRAIN;
        end else begin
          w_pc_wr   = 1'b1;
          w_ifid_wr = 1'b1;
          w_ex_nxt  = '{rd: bus.id_rd, wr: bus.id_reg_write, ld: bus.id_mem_read};
        end
      end
      ST_DRAIN: begin
        w_hz = 1'b1;
        if (r_cnt != 4'd0) w_cnt_nxt = r_cnt - 4'd1;
        // A zero count can only come from an illegal DRAIN_CYCLES; still terminate.
        if (r_cnt <= 4'd1) w_state_nxt = ST_HALTED;
      end
      ST_HALTED: begin
        w_hz   = 1'b1;
        w_done = 1'b1;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_RUN;
      r_cnt    <= 4'd0;
      r_ex     <= '0;
      r_mem_rd <= 5'd0;
      r_mem_wr <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_ex     <= w_ex_nxt;
      r_mem_rd <= r_ex.rd;
      r_mem_wr <= r_ex.wr;
    end
  end

  // Outputs are gated so the pipeline is frozen for the whole reset pulse.
  assign bus.hazard_detected = w_hz      & rst_n;
  assign bus.pc_write        = w_pc_wr   & rst_n;
  assign bus.ifid_write      = w_ifid_wr & rst_n;
  assign bus.ifid_flush      = w_ifid_fl & rst_n;
  assign bus.idex_flush      = w_idex_fl & rst_n;
  assign bus.halt_done       = w_done    & rst_n;

endmodule

// File: doc/pipeline_hazard_ctl.md
Name: pipeline_hazard_ctl

Overview:
Hazard and sequencing controller for the 5-stage RISC-V pipeline. It drives the hazard_detected input of the ID-stage control decoder, plus the PC and IF/ID write enables and the flush strobes.
- Internally it keeps a shadow copy of the destination info of in-flight instructions in EX and MEM, and uses it to detect RAW and load-use hazards.
- It squashes wrong-path instructions on a taken branch.
- It sequences HALT: the pipeline drains, then HALTED is reported.

Parameters:
FORWARDING, 1, 1 = full EX/MEM forwarding present, so only load-use stalls; 0 = stall on any RAW against EX or MEM writers.
DRAIN_CYCLES, 3, cycles to drain older instructions after HALT leaves ID (EX, MEM, WB); legal range 1..15.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
id_rs1  input  5  rs1 field of the instruction in ID.
id_rs2  input  5  rs2 field of the instruction in ID.
id_use_rs1  input  1  ID instruction reads rs1.
id_use_rs2  input  1  ID instruction reads rs2.
id_rd  input  5  rd field of the instruction in ID.
id_reg_write  input  1  reg_write from the decoder (unstalled value).
id_mem_read  input  1  mem_read from the decoder (unstalled value).
id_halt  input  1  halt from the decoder.
ex_branch_taken  input  1  BEQ resolved taken in EX this cycle.
hazard_detected  output  1  forces decoder controls to bubble.
pc_write  output  1  PC register update enable.
ifid_write  output  1  IF/ID register update enable.
ifid_flush  output  1  clear IF/ID to NOP.
idex_flush  output  1  clear ID/EX to bubble.
halt_done  output  1  pipeline drained after HALT; sticky.

Behaviour:
- Reset (async, rst_n=0): state=RUN, counter=0, shadow regs cleared (ex_rd=0, ex_wr=0, ex_ld=0, mem_rd=0, mem_wr=0).
- Reset outputs: hazard_detected=0, pc_write=0, ifid_write=0, ifid_flush=0, idex_flush=0, halt_done=0. These are forced while rst_n is low.
- Reset mid-DRAIN or in HALTED fully aborts the halt sequence.
- States: RUN, DRAIN, HALTED.
- Shadow update every clock in RUN: mem_* <= ex_*.
  - ex_* <= ID info (id_rd, id_reg_write, id_mem_read) when the ID instruction advances.
  - ex_* <= bubble (all 0) on stall, flush or halt entry.
- hit(r) = (r != 0) & (id_use & id_rs == r). Any rd=0 writer never causes a hazard.
- FORWARDING=1: stall = ex_ld & ex_wr & hit(ex_rd).
- FORWARDING=0: stall = (ex_wr & hit(ex_rd)) | (mem_wr & hit(mem_rd)).
- Priority in RUN, evaluated each cycle:
  1. ex_branch_taken: ifid_flush=1, idex_flush=1, hazard_detected=1. pc_write=1 (the branch target loads) and ifid_write=1. Stall and halt are ignored because the ID instruction is wrong-path.
  2. stall: pc_write=0, ifid_write=0, hazard_detected=1. Exactly 1 cycle for load-use; up to 2 cycles for FORWARDING=0.
  3. id_halt: go to DRAIN next cycle with counter=DRAIN_CYCLES. hazard_detected=1, pc_write=0, ifid_write=0.
  4. else: pc_write=1, ifid_write=1, all other outputs 0.
- DRAIN:
  - Outputs: pc_write=0, ifid_write=0, hazard_detected=1, no flushes.
  - Counter decrements each cycle; the shadow keeps shifting bubbles.
  - Go to HALTED when the counter reaches 1 and decrements.
  - ex_branch_taken cannot occur in DRAIN (no older branch remains) and is ignored.
- HALTED: halt_done=1, pc_write=0, ifid_write=0, hazard_detected=1. Terminal state until reset.
- Counter width: 4 bits. No wrap; the counter saturates at 0.

Decomposition:
- Shared package: state encoding (RUN=2'd0, DRAIN=2'd1, HALTED=2'd2), the x0 register constant, and opcode constants (R_FORMAT, I_FORMAT, LOAD, STORE, BEQ) shared with the decoder.
- One sub-module, hazard_cmp: combinational rs/rd match and stall equation, parameterised by FORWARDING.
- FSM, counter and shadow registers stay in the top module.

Test Plan:
1. Load-use: LOAD x5 enters EX; the next ID instruction has rs1=5, use_rs1=1, FORWARDING=1 -> exactly 1 cycle of hazard_detected=1, pc_write=0, ifid_write=0; the next cycle is all clear.
2. x0 writer: LOAD x0 followed by a consumer with rs2=0 -> no stall, pc_write stays 1.
3. FORWARDING=0: ADD x3 followed by a consumer with rs1=3 -> 2 stall cycles. The same scenario with FORWARDING=1 -> 0 stall cycles.
4. Branch and stall together: ex_branch_taken=1 while a load-use condition exists in ID -> ifid_flush=1, idex_flush=1, pc_write=1, no stall. The following cycle is clean.
5. HALT, DRAIN_CYCLES=3: id_halt=1 at cycle t -> pc_write=0 from t. halt_done=1 at t+4 and stays 1 for 10 further cycles.
6. Reset abort: rst_n pulled low at t+2 of DRAIN -> outputs at reset values immediately. After release with id_halt=0: state RUN, halt_done=0, pc_write=1.
